// File: rtl/jk_reg_bank_if.sv
// Bus bundle for the JK register bank: control/data inputs and the state/status
// outputs. The master drives the controls and the slave (the bank) drives the status.
interface jk_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             clr_cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] changed;
  logic [CNT_W-1:0] toggle_cnt;
  logic             cnt_sat;

  modport master (
    output en, j, k, load, load_data, clr_cnt,
    input  q, qn, changed, toggle_cnt, cnt_sat
  );

  modport slave (
    input  en, j, k, load, load_data, clr_cnt,
    output q, qn, changed, toggle_cnt, cnt_sat
  );
endinterface

// File: rtl/jk_reg_bank.sv
// Vector of independent JK flip-flops with parallel load, a per-bit change flag
// and a saturating count of toggle events. The reset is synchronous and active-low.
module jk_reg_bank #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  parameter int               CNT_W = 8
) (
  input logic          clk,
  input logic          reset,
  jk_reg_bank_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   changed_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   q_next_s;
  logic [6:0]         inc_s;
  logic [CNT_W+6:0]   sum_s;
  logic [CNT_W-1:0]   cnt_next_s;

  // Up to 64 channels, so seven bits always hold the count of set bits.
  function automatic logic [6:0] popcount(input logic [WIDTH-1:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        n = n + 7'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Next channel state: load beats the JK update, which happens only when enabled.
  always_comb begin
    q_next_s = q_r;
    if (bus.load) begin
      q_next_s = bus.load_data;
    end else if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({bus.j[i], bus.k[i]})
          2'b00:   q_next_s[i] = q_r[i];
          2'b01:   q_next_s[i] = 1'b0;
          2'b10:   q_next_s[i] = 1'b1;
          2'b11:   q_next_s[i] = ~q_r[i];
          default: q_next_s[i] = q_r[i];
        endcase
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Toggle events are counted only on a plain enabled JK update. The wide sum is clamped at the maximum.
  always_comb begin
    inc_s = 7'd0;
    if (bus.en && !bus.load) begin
      inc_s = popcount(bus.j & bus.k);
    end else begin
      inc_s = 7'd0;
    end
    sum_s = {7'd0, cnt_r} + {{CNT_W{1'b0}}, inc_s};
    if (sum_s > {7'd0, CNT_MAX}) begin
      cnt_next_s = CNT_MAX;
    end else begin
      cnt_next_s = sum_s[CNT_W-1:0];
    end
  end

  // State registers: the reset overrides everything, and a counter clear discards that edge's increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r       <= INIT;
      changed_r <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      q_r       <= q_next_s;
      changed_r <= q_next_s ^ q_r;
      if (bus.clr_cnt) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_next_s;
      end
    end
  end

  assign bus.q          = q_r;
  assign bus.qn         = ~q_r;
  assign bus.changed    = changed_r;
  assign bus.toggle_cnt = cnt_r;
  assign bus.cnt_sat    = (cnt_r == CNT_MAX);
endmodule

// File: doc/jk_reg_bank.md
Name: jk_reg_bank

Overview:
- Parametrised vector of JK flip-flops with WIDTH independent channels sharing one clock.
- Adds the following over a single JK cell: synchronous active-low reset to a configurable pattern, global clock enable, and synchronous parallel load.
- Also provides a registered per-channel change flag and a saturating counter of toggle events.
- Used as a general control/status register bank where software or FSMs set, clear and toggle bits independently.

Parameters:
- WIDTH, 8, number of JK channels (1..64).
- INIT, {WIDTH{1'b0}}, value q takes during reset.
- CNT_W, 8, width of the toggle-event counter (2..32).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk.
- en  input  1  global enable; JK update only when 1.
- j  input  WIDTH  per-channel J inputs.
- k  input  WIDTH  per-channel K inputs.
- load  input  1  synchronous parallel load strobe.
- load_data  input  WIDTH  value written to q when load=1.
- clr_cnt  input  1  synchronous clear of toggle_cnt.
- q  output  WIDTH  registered channel state.
- qn  output  WIDTH  combinational ~q.
- changed  output  WIDTH  registered; bit i=1 iff q[i] changed at the most recent clock edge.
- toggle_cnt  output  CNT_W  saturating count of channel toggle events.
- cnt_sat  output  1  combinational; 1 when toggle_cnt is all ones.

Behaviour:
- Reset (reset=0 at rising clk): q<=INIT, changed<=0, toggle_cnt<=0. Reset overrides every other input. No asynchronous path exists: reset going low between edges does not alter outputs until the next edge.
- Per-edge priority for q: reset > load > en > hold.
  - load=1: q<=load_data regardless of en, j, k.
  - load=0, en=1: per channel i, {j[i],k[i]}=00 hold, 01 q[i]<=0, 10 q[i]<=1, 11 q[i]<=~q[i].
  - load=0, en=0: q holds.
- changed: each non-reset edge, changed<=q_next^q_current, where q_next is the value q takes at that edge.
  - changed therefore appears in the same cycle as the new q and lasts one cycle unless q changes again.
  - Load of an identical value gives changed=0.
- toggle_cnt:
  - A toggle event is a channel with j=k=1 in a cycle where en=1, load=0, reset=1.
  - Each edge adds N = popcount(j&k) under those conditions, else 0.
  - Sum computed at CNT_W+7 bits; result clamps to 2^CNT_W-1 if it would exceed it. There is no wrap-around.
  - clr_cnt=1 (reset=1): toggle_cnt<=0 and that edge's increment is discarded (clear wins).
  - Once saturated, toggle_cnt stays at max until clr_cnt or reset.
- Latency: q, changed and toggle_cnt update one edge after inputs are sampled. qn and cnt_sat follow their sources combinationally.
- Inputs j, k, load_data are don't-care while reset=0 or when the operation does not use them. X on unused inputs must not propagate.
- Mid-operation reset: an edge with reset=0 discards any simultaneous load or toggle. The counter increment in that cycle is lost.

Test Plan (WIDTH=4, INIT=4'b1010, CNT_W=4):
- Reset=0 for 2 edges with j=k=4'hF, en=1, load=1 -> q=4'b1010, qn=4'b0101, changed=0, toggle_cnt=0.
- Release reset; en=1, j=4'b0011, k=4'b0101 for one edge from q=1010 -> bit0 toggles to 1, bit1 sets to 1, bit2 clears to 0, bit3 holds at 1. Result q=4'b1011, changed=4'b0001, toggle_cnt=1.
- load=1, en=1, load_data=4'b0110, j=k=4'hF -> q=0110, changed=1101, toggle_cnt unchanged. Next edge with en=0, j=k=4'hF -> q holds, changed=0, count unchanged.
- en=1, j=k=4'hF for 4 edges from count=1 -> counts 5, 9, 13, then 15 (saturated, cnt_sat=1). q alternates each edge and changed=4'hF each edge.
- At toggle_cnt=15 drive clr_cnt=1 with j=k=4'hF, en=1 -> toggle_cnt=0 (increment discarded), q still toggles.
- With j=k=4'hF, en=1, pulse reset=0 for one edge -> q=1010, changed=0, toggle_cnt=0. Next edge with reset=1 -> q=0101, toggle_cnt=4.
